inv_sweep_checker: RTL and testbench

Parametrised, self-checking exhaustive sweep engine for N-channel bitwise inverters. After a start pulse it drives every value 0 … 2^WIDTH−1 onto a shared stimulus bus. It waits a programmable settle time, then compares each channel's returned word against the bitwise complement of the stimulus. It accumulates a pass/fail summary. It sits beside the multi-language inverter top and replaces hand-written vector lists with a synthesizable, cycle-exact sweep.

---
 rtl/inv_sweep_checker.sv | 201 ++++++++++++++++++++
 tb/tb_inv_sweep_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sweep_checker.sv
// inv_sweep_checker: exhaustive sweep engine for N parallel bitwise inverters.
// Drives every WIDTH-bit value onto a shared stimulus bus, waits SETTLE cycles,
// then checks each channel's returned word against the complement of the
// stimulus and accumulates a pass/fail summary. All outputs are registered.
module inv_sweep_checker #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 3,
   parameter int SETTLE   = 1,
   parameter int ERR_W    = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [CHANNELS*WIDTH-1:0] y_in,
   output logic [WIDTH-1:0]          a_out,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [ERR_W-1:0]          err_count,
   output logic [CHANNELS-1:0]       err_chan_mask,
   output logic [WIDTH-1:0]          first_err_value,
   output logic                      first_err_valid
);

   // Width of the per-cycle mismatch increment (0..CHANNELS).
   localparam int INC_W = $clog2(CHANNELS + 1);
   // Sum is one bit wider than either operand so saturation never sees a wrap.
   localparam int SUM_W = ((ERR_W > INC_W) ? ERR_W : INC_W) + 1;
   // Settle counter counts 0..SETTLE-1; keep at least one bit when SETTLE<=1.
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [WIDTH-1:0] A_LAST   = '1;
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_CHECK = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   // With no settle time a new vector is checked in the very next cycle.
   localparam state_t AFTER_STEP = (SETTLE > 0) ? S_WAIT : S_CHECK;

   // Number of set bits in the mismatch vector.
   function automatic logic [INC_W-1:0] count_ones(input logic [CHANNELS-1:0] v);
      logic [INC_W-1:0] n;
      n = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         n = n + INC_W'(v[k]);
      end
      return n;
   endfunction

   // Saturating accumulate: clamps at all-ones instead of wrapping.
   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                input logic [INC_W-1:0] inc);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(acc) + SUM_W'(inc);
      if (sum > SUM_W'(ERR_MAX)) begin
         return ERR_MAX;
      end else begin
         return sum[ERR_W-1:0];
      end
   endfunction

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]      a_q, a_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic [ERR_W-1:0]      err_q, err_d;
   logic [CHANNELS-1:0]   mask_q, mask_d;
   logic [WIDTH-1:0]      fev_q, fev_d;
   logic                  fvld_q, fvld_d;
   logic [CHANNELS-1:0]   mism;

   // Per-channel mismatch against the complement of the current stimulus.
   always_comb begin
      mism = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         mism[k] = (y_in[k*WIDTH +: WIDTH] != ~a_q);
      end
   end

   // Next-state and result update; abort outranks completion of a CHECK.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      mask_d  = mask_q;
      fev_d   = fev_q;
      fvld_d  = fvld_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = '0;
               err_d   = '0;
               mask_d  = '0;
               fev_d   = '0;
               fvld_d  = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = AFTER_STEP;
            end
         end

         S_WAIT: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_CHECK: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               pass_d  = 1'b0;
            end else begin
               err_d  = sat_add(err_q, count_ones(mism));
               mask_d = mask_q | mism;
               if ((|mism) && !fvld_q) begin
                  fev_d  = a_q;
                  fvld_d = 1'b1;
               end
               if (a_q == A_LAST) begin
                  // Last vector: busy drops and done rises together in FIN.
                  state_d = S_FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0);
               end else begin
                  a_d     = a_q + WIDTH'(1);
                  cnt_d   = '0;
                  state_d = AFTER_STEP;
               end
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and result registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         mask_q  <= '0;
         fev_q   <= '0;
         fvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
         fev_q   <= fev_d;
         fvld_q  <= fvld_d;
      end
   end

   assign a_out           = a_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign err_chan_mask   = mask_q;
   assign first_err_value = fev_q;
   assign first_err_valid = fvld_q;

endmodule

// File: tb/tb_inv_sweep_checker.sv
// Directed bench for inv_sweep_checker: a SETTLE=1/ERR_W=8 instance and a
// SETTLE=0/ERR_W=4 instance, each fed by a behavioural inverter model with
// selectable faults.
module tb_inv_sweep_checker;

   localparam int W  = 4;
   localparam int CH = 3;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   logic start1 = 1'b0, abort1 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
   logic [CH*W-1:0] y1, y2;
   logic [W-1:0]    a1, a2, fev1, fev2;
   logic            busy1, done1, pass1, fvld1;
   logic            busy2, done2, pass2, fvld2;
   logic [7:0]      err1;
   logic [3:0]      err2;
   logic [CH-1:0]   mask1, mask2;

   int   mode1 = 0, mode2 = 0;   // 0 ideal, 1 ch1 bit0 stuck-at-0, 2 pass-through
   int   errors = 0, checks = 0;
   logic cur = 1'b0;             // 0 selects instance 1, 1 selects instance 2

   always #5 clk = ~clk;

   inv_sweep_checker #(.WIDTH(W), .CHANNELS(CH), .SETTLE(1), .ERR_W(8)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1), .y_in(y1),
      .a_out(a1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .err_chan_mask(mask1), .first_err_value(fev1), .first_err_valid(fvld1));

   inv_sweep_checker #(.WIDTH(W), .CHANNELS(CH), .SETTLE(0), .ERR_W(4)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .abort(abort2), .y_in(y2),
      .a_out(a2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .err_chan_mask(mask2), .first_err_value(fev2), .first_err_valid(fvld2));

   // Behavioural inverter channels under test.
   function automatic logic [CH*W-1:0] model(input int mode, input logic [W-1:0] a);
      logic [CH*W-1:0] y;
      y = '0;
      for (int k = 0; k < CH; k++) begin
         case (mode)
            1:       y[k*W +: W] = (k == 1) ? (~a & 4'hE) : ~a;
            2:       y[k*W +: W] = a;
            default: y[k*W +: W] = ~a;
         endcase
      end
      return y;
   endfunction

   assign y1 = model(mode1, a1);
   assign y2 = model(mode2, a2);

   wire         busy_m = cur ? busy2 : busy1;
   wire         done_m = cur ? done2 : done1;
   wire         pass_m = cur ? pass2 : pass1;
   wire         fvld_m = cur ? fvld2 : fvld1;
   wire [W-1:0] a_m    = cur ? a2 : a1;
   wire [W-1:0] fev_m  = cur ? fev2 : fev1;
   wire [CH-1:0] mask_m = cur ? mask2 : mask1;
   wire [7:0]   err_m  = cur ? {4'b0, err2} : err1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (cur) start2 = v;
      else     start1 = v;
   endtask

   task automatic start_only();
      @(negedge clk); set_start(1'b1);
      @(negedge clk); set_start(1'b0);
   endtask

   // Wait (bounded) until the selected instance is busy with a_out == v.
   task automatic wait_a(input logic [W-1:0] v, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (busy_m && a_m == v) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // One full sweep over a fixed 40-cycle window; optionally re-pulses start
   // at window cycle restart_at to show it is ignored while busy.
   task automatic run_sweep(input int settle, input int restart_at,
                            output int nbusy, output int ndone,
                            output bit seq_ok, output bit busy_in_done,
                            output bit cleared);
      nbusy = 0; ndone = 0; seq_ok = 1'b1; busy_in_done = 1'b0; cleared = 1'b0;
      start_only();
      for (int j = 0; j < 40; j++) begin
         if (j == 0) begin
            cleared = busy_m && (a_m == '0) && (err_m == '0) && (mask_m == '0) &&
                      !fvld_m && !pass_m;
         end
         if (busy_m) begin
            if (a_m != W'(nbusy / (settle + 1))) seq_ok = 1'b0;
            nbusy++;
         end
         if (done_m) begin
            ndone++;
            if (busy_m) busy_in_done = 1'b1;
         end
         set_start(j == restart_at);
         @(negedge clk);
      end
      set_start(1'b0);
   endtask

   initial begin
      int nb, nd;
      bit sq, bid, clr, ok;

      // Asynchronous reset, checked before any clock edge acts on it.
      #3 reset_n = 1'b0;
      #1;
      chk("rst_busy",  busy1, 0);
      chk("rst_done",  done1, 0);
      chk("rst_pass",  pass1, 0);
      chk("rst_a",     a1, 0);
      chk("rst_err",   err1, 0);
      chk("rst_mask",  mask1, 0);
      chk("rst_fvld",  fvld1, 0);
      chk("rst_fev",   fev1, 0);
      chk("rst2_busy", busy2, 0);
      @(negedge clk); reset_n = 1'b1;

      // Ideal channels, SETTLE=1.
      cur = 1'b0; mode1 = 0;
      run_sweep(1, -1, nb, nd, sq, bid, clr);
      chk("ideal_busy_cycles", nb, 32);
      chk("ideal_done_count",  nd, 1);
      chk("ideal_a_seq",       sq, 1);
      chk("ideal_busy_in_done", bid, 0);
      chk("ideal_start_clear", clr, 1);
      chk("ideal_pass",  pass1, 1);
      chk("ideal_err",   err1, 0);
      chk("ideal_mask",  mask1, 0);
      chk("ideal_fvld",  fvld1, 0);
      chk("ideal_a_hold", a1, 15);

      // Channel 1 bit 0 stuck at 0: mismatch on every even stimulus.
      mode1 = 1;
      run_sweep(1, -1, nb, nd, sq, bid, clr);
      chk("stuck_busy_cycles", nb, 32);
      chk("stuck_done_count",  nd, 1);
      chk("stuck_err",  err1, 8);
      chk("stuck_mask", mask1, 3'b010);
      chk("stuck_fev",  fev1, 0);
      chk("stuck_fvld", fvld1, 1);
      chk("stuck_pass", pass1, 0);

      // start re-pulsed mid-sweep is ignored; previous errors cleared on start.
      mode1 = 0;
      run_sweep(1, 10, nb, nd, sq, bid, clr);
      chk("restart_busy_cycles", nb, 32);
      chk("restart_done_count",  nd, 1);
      chk("restart_a_seq",       sq, 1);
      chk("restart_start_clear", clr, 1);
      chk("restart_pass",        pass1, 1);

      // Abort while a_out=5 with the stuck fault present.
      mode1 = 1;
      start_only();
      wait_a(4'd5, ok);
      chk("abort_reach_5", ok, 1);
      abort1 = 1'b1;
      @(negedge clk); abort1 = 1'b0;
      chk("abort_busy", busy1, 0);
      chk("abort_a",    a1, 5);
      chk("abort_pass", pass1, 0);
      chk("abort_err",  err1, 3);
      chk("abort_mask", mask1, 3'b010);
      chk("abort_fvld", fvld1, 1);
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         if (done1) nd++;
         @(negedge clk);
      end
      chk("abort_no_done", nd, 0);
      chk("abort_a_frozen", a1, 5);
      mode1 = 0;
      run_sweep(1, -1, nb, nd, sq, bid, clr);
      chk("post_abort_clear", clr, 1);
      chk("post_abort_busy",  nb, 32);
      chk("post_abort_a_seq", sq, 1);
      chk("post_abort_pass",  pass1, 1);

      // Reset mid-sweep at a_out=9.
      mode1 = 1;
      start_only();
      wait_a(4'd9, ok);
      chk("rstmid_reach_9", ok, 1);
      chk("rstmid_err_before", err1, 5);
      #3 reset_n = 1'b0;
      #1;
      chk("rstmid_busy", busy1, 0);
      chk("rstmid_a",    a1, 0);
      chk("rstmid_err",  err1, 0);
      chk("rstmid_mask", mask1, 0);
      chk("rstmid_fvld", fvld1, 0);
      chk("rstmid_done", done1, 0);
      @(negedge clk); reset_n = 1'b1;
      mode1 = 0;
      run_sweep(1, -1, nb, nd, sq, bid, clr);
      chk("post_rst_busy", nb, 32);
      chk("post_rst_done", nd, 1);
      chk("post_rst_pass", pass1, 1);
      chk("post_rst_err",  err1, 0);

      // SETTLE=0, ERR_W=4 instance: ideal sweep.
      cur = 1'b1; mode2 = 0;
      run_sweep(0, -1, nb, nd, sq, bid, clr);
      chk("s0_busy_cycles", nb, 16);
      chk("s0_done_count",  nd, 1);
      chk("s0_a_seq",       sq, 1);
      chk("s0_busy_in_done", bid, 0);
      chk("s0_pass", pass2, 1);
      chk("s0_err",  err2, 0);

      // All channels pass stimulus through: 48 mismatches saturate at 15.
      mode2 = 2;
      run_sweep(0, -1, nb, nd, sq, bid, clr);
      chk("sat_busy_cycles", nb, 16);
      chk("sat_err",  err2, 15);
      chk("sat_mask", mask2, 3'b111);
      chk("sat_fev",  fev2, 0);
      chk("sat_fvld", fvld2, 1);
      chk("sat_pass", pass2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
